// File: rtl/am2940_dma_sequencer_pkg.sv
// ============================================================================
// am2940_pkg : AM2940 opcodes, sequencer state encoding, reset instruction
// Rev 1.0
// ============================================================================
`default_nettype none

package am2940_pkg;

  localparam logic [2:0] OP_WR_CTRL = 3'b000;
  localparam logic [2:0] OP_RD_CTRL = 3'b001;
  localparam logic [2:0] OP_RD_WC   = 3'b010;
  localparam logic [2:0] OP_RD_AC   = 3'b011;
  localparam logic [2:0] OP_REINIT  = 3'b100;
  localparam logic [2:0] OP_LD_ADDR = 3'b101;
  localparam logic [2:0] OP_LD_WC   = 3'b110;
  localparam logic [2:0] OP_ENABLE  = 3'b111;

  // RD_CTRL is side-effect free, so it is what the generator sees while idle
  localparam logic [2:0] INSTR_RESET = OP_RD_CTRL;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CTRL   = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WC     = 3'd3,
    ST_VERIFY = 3'd4,
    ST_RUN    = 3'd5,
    ST_FINISH = 3'd6,
    ST_ABORT  = 3'd7
  } state_e;

endpackage

`default_nettype wire

// File: rtl/am2940_dma_sequencer_if.sv
// ============================================================================
// am2940_dma_sequencer_if : host request, memory handshake and AM2940 bus
// Rev 1.0
// ============================================================================
`default_nettype none

interface am2940_dma_sequencer_if #(
  parameter int DATA_W = 8
);
  logic              Start;
  logic [DATA_W-1:0] StartAddress;
  logic [DATA_W-1:0] WordCount;
  logic [2:0]        ControlWord;
  logic              Abort;
  logic              MemAck;
  logic              Done;
  logic [DATA_W-1:0] AmDataIn;
  logic [2:0]        Instruction;
  logic [DATA_W-1:0] AmDataOut;
  logic              ACI;
  logic              WCI;
  logic              MemReq;
  logic              Busy;
  logic              XferDone;
  logic              Error;

  modport master (
    output Start, StartAddress, WordCount, ControlWord, Abort, MemAck, Done, AmDataIn,
    input  Instruction, AmDataOut, ACI, WCI, MemReq, Busy, XferDone, Error
  );

  modport slave (
    input  Start, StartAddress, WordCount, ControlWord, Abort, MemAck, Done, AmDataIn,
    output Instruction, AmDataOut, ACI, WCI, MemReq, Busy, XferDone, Error
  );
endinterface

`default_nettype wire

// File: rtl/am2940_dma_sequencer_ack_timeout_timer.sv
// ============================================================================
// ack_timeout_timer : counts consecutive enabled cycles, flags the LIMIT-th one
// Rev 1.0
// ============================================================================
`default_nettype none

module ack_timeout_timer #(
  parameter int LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);
  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable && (cnt_q != CW'(LIMIT))) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires during the LIMIT-th waiting cycle so the abort lands on its closing edge
  assign expired = enable && !clear && (cnt_q == CW'(LIMIT - 1));

endmodule

`default_nettype wire

// File: rtl/am2940_dma_sequencer.sv
// ============================================================================
// am2940_dma_sequencer : loads and paces an AM2940 address generator per request
// Optional readback of the control register: define READBACK_VERIFY_EN.  Rev 1.0
// ============================================================================
`default_nettype none

module am2940_dma_sequencer
  import am2940_pkg::*;
#(
  parameter int DATA_W      = 8,
  parameter int ACK_TIMEOUT = 0
) (
  input  logic                   clk,
  input  logic                   Reset_n,
  am2940_dma_sequencer_if.slave  bus
);

  state_e            state_q, state_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [DATA_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wc_q, wc_d;
  logic [2:0]        instr_q, instr_d;
  logic [DATA_W-1:0] amdata_q, amdata_d;
  logic              cnt_n_q, cnt_n_d;
  logic              memreq_q, memreq_d;
  logic              busy_q, busy_d;
  logic              xfer_q, xfer_d;
  logic              error_q, error_d;
  logic              step;
  logic              ack_expired;

  generate
    if (ACK_TIMEOUT > 0) begin : g_ack_timeout
      ack_timeout_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
        .clk     (clk),
        .rst_n   (Reset_n),
        .clear   ((state_q != ST_RUN) || bus.MemAck),
        .enable  (state_q == ST_RUN),
        .expired (ack_expired)
      );
    end else begin : g_no_ack_timeout
      assign ack_expired = 1'b0;
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ctrl_d  = ctrl_q;
    addr_d  = addr_q;
    wc_d    = wc_q;
    error_d = error_q;
    step    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.Start) begin
          ctrl_d  = bus.ControlWord;
          addr_d  = bus.StartAddress;
          wc_d    = bus.WordCount;
          error_d = 1'b0;
          state_d = ST_CTRL;
        end
      end
      ST_CTRL: state_d = ST_ADDR;
      ST_ADDR: state_d = ST_WC;
`ifdef READBACK_VERIFY_EN
      ST_WC:   state_d = ST_VERIFY;
      ST_VERIFY: begin
        if (bus.AmDataIn[2:0] != ctrl_q) begin
          error_d = 1'b1;
          state_d = ST_ABORT;
        end else begin
          state_d = ST_RUN;
        end
      end
`else
      ST_WC:   state_d = ST_RUN;
`endif
      ST_RUN: begin
        if (bus.MemAck) begin
          step = 1'b1;
          if (bus.Done) begin
            state_d = ST_FINISH;
          end
        end else if (ack_expired) begin
          error_d = 1'b1;
          state_d = ST_ABORT;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // A host abort overrides everything, including a word acknowledged this cycle
    if (bus.Abort && (state_q != ST_IDLE) && (state_q != ST_ABORT)) begin
      state_d = ST_ABORT;
      step    = 1'b0;
    end
  end

  // Outputs are registered images of the state being entered
  always_comb begin
    instr_d  = INSTR_RESET;
    amdata_d = amdata_q;
    case (state_d)
      ST_CTRL: begin
        instr_d  = OP_WR_CTRL;
        amdata_d = DATA_W'(ctrl_d);
      end
      ST_ADDR: begin
        instr_d  = OP_LD_ADDR;
        amdata_d = addr_d;
      end
      ST_WC: begin
        instr_d  = OP_LD_WC;
        amdata_d = wc_d;
      end
      ST_RUN:    instr_d = OP_ENABLE;
      ST_FINISH: instr_d = OP_ENABLE;
      ST_ABORT:  instr_d = OP_REINIT;
      default:   instr_d = INSTR_RESET;
    endcase
    cnt_n_d  = !step;
    memreq_d = (state_d == ST_RUN);
    busy_d   = (state_d != ST_IDLE);
    xfer_d   = (state_d == ST_FINISH);
  end

  always_ff @(posedge clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q  <= ST_IDLE;
      ctrl_q   <= '0;
      addr_q   <= '0;
      wc_q     <= '0;
      instr_q  <= INSTR_RESET;
      amdata_q <= '0;
      cnt_n_q  <= 1'b1;
      memreq_q <= 1'b0;
      busy_q   <= 1'b0;
      xfer_q   <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      addr_q   <= addr_d;
      wc_q     <= wc_d;
      instr_q  <= instr_d;
      amdata_q <= amdata_d;
      cnt_n_q  <= cnt_n_d;
      memreq_q <= memreq_d;
      busy_q   <= busy_d;
      xfer_q   <= xfer_d;
      error_q  <= error_d;
    end
  end

  assign bus.Instruction = instr_q;
  assign bus.AmDataOut   = amdata_q;
  assign bus.ACI         = cnt_n_q;
  assign bus.WCI         = cnt_n_q;
  assign bus.MemReq      = memreq_q;
  assign bus.Busy        = busy_q;
  assign bus.XferDone    = xfer_q;
  assign bus.Error       = error_q;

endmodule

`default_nettype wire

// File: tb/tb_am2940_dma_sequencer.sv
// ============================================================================
// tb_am2940_dma_sequencer : sequencer with behavioural AM2940 counters and memory ack model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_am2940_dma_sequencer;
  import am2940_pkg::*;

  localparam int DW = 8;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 clk = ~clk;

  am2940_dma_sequencer_if #(.DATA_W(DW)) bus();

  am2940_dma_sequencer #(.DATA_W(DW), .ACK_TIMEOUT(TO)) dut (
    .clk     (clk),
    .Reset_n (Reset_n),
    .bus     (bus.slave)
  );

  // Behavioural AM2940: registers load on their opcodes, counters step when enabled
  logic [DW-1:0] am_addr, am_wc;
  logic [2:0]    am_ctrl;
  always @(posedge clk) begin
    case (bus.Instruction)
      OP_WR_CTRL: am_ctrl <= bus.AmDataOut[2:0];
      OP_LD_ADDR: am_addr <= bus.AmDataOut;
      OP_LD_WC:   am_wc   <= bus.AmDataOut;
      OP_ENABLE: begin
        if (!bus.ACI) am_addr <= am_addr + 1'b1;
        if (!bus.WCI) am_wc   <= am_wc - 1'b1;
      end
      default: ;
    endcase
  end

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drives a request and walks the load phase; returns one cycle into RUN (or ABORT)
  task automatic start_xfer(input logic [DW-1:0] a, input logic [DW-1:0] w,
                            input logic [2:0] c, input bit corrupt);
    bus.StartAddress = a;
    bus.WordCount    = w;
    bus.ControlWord  = c;
    bus.AmDataIn     = DW'(corrupt ? (c ^ 3'b001) : c);
    bus.Start        = 1'b1;
    tick();
    bus.Start = 1'b0;
    check("ctrl_op",   bus.Instruction, OP_WR_CTRL);
    check("ctrl_data", bus.AmDataOut, c);
    check("busy_set",  bus.Busy, 1);
    check("err_clear", bus.Error, 0);
    tick();
    check("addr_op",   bus.Instruction, OP_LD_ADDR);
    check("addr_data", bus.AmDataOut, a);
    tick();
    check("wc_op",     bus.Instruction, OP_LD_WC);
    check("wc_data",   bus.AmDataOut, w);
    check("load_noreq", bus.MemReq, 0);
`ifdef READBACK_VERIFY_EN
    tick();
    check("verify_op", bus.Instruction, OP_RD_CTRL);
`endif
    tick();
  endtask

  // mode 0: random acks, 1: continuous, 2: every 2nd cycle; abort_at = ack index to abort on
  task automatic run_words(input int wc, input int mode, input int abort_at);
    int acks = 0;
    int gap  = 0;
    int cyc  = 0;
    bit ack, ab;
    check("run_op",  bus.Instruction, OP_ENABLE);
    check("run_req", bus.MemReq, 1);
    check("run_aci", bus.ACI, 1);
    while (acks < wc) begin
      case (mode)
        1:       ack = 1'b1;
        2:       ack = (cyc % 2) == 1;
        default: ack = (gap >= 4) || ($urandom_range(0, 2) != 0);
      endcase
      ab = ack && (acks == abort_at);
      bus.MemAck = ack;
      bus.Done   = (acks == wc - 1);
      bus.Abort  = ab;
      if ($urandom_range(0, 3) == 0) begin
        bus.Start        = 1'b1;
        bus.StartAddress = DW'($urandom);
        bus.WordCount    = DW'($urandom);
        bus.ControlWord  = 3'($urandom);
      end
      tick();
      bus.MemAck = 1'b0;
      bus.Done   = 1'b0;
      bus.Abort  = 1'b0;
      bus.Start  = 1'b0;
      cyc++;
      if (ab) begin
        check("abort_op",   bus.Instruction, OP_REINIT);
        check("abort_aci",  bus.ACI, 1);
        check("abort_wci",  bus.WCI, 1);
        check("abort_req",  bus.MemReq, 0);
        check("abort_done", bus.XferDone, 0);
        tick();
        check("abort_idle", bus.Busy, 0);
        check("abort_nodone", bus.XferDone, 0);
        return;
      end
      if (ack) begin
        acks++;
        gap = 0;
        check("step_aci", bus.ACI, 0);
        check("step_wci", bus.WCI, 0);
        if (acks == wc) begin
          check("xfer_done", bus.XferDone, 1);
          check("fin_noreq", bus.MemReq, 0);
          check("fin_busy",  bus.Busy, 1);
          tick();
          check("idle_busy", bus.Busy, 0);
          check("done_1cyc", bus.XferDone, 0);
          check("idle_aci",  bus.ACI, 1);
          check("idle_op",   bus.Instruction, OP_RD_CTRL);
        end else begin
          check("next_req",  bus.MemReq, 1);
          check("no_done",   bus.XferDone, 0);
        end
      end else begin
        gap++;
        check("wait_aci", bus.ACI, 1);
        check("wait_req", bus.MemReq, 1);
      end
    end
  endtask

  task automatic full_xfer(input logic [DW-1:0] a, input int wc, input logic [2:0] c, input int mode);
    start_xfer(a, DW'(wc), c, 1'b0);
    run_words(wc, mode, -1);
    check("am_addr_end", am_addr, DW'(a + wc));
    check("am_wc_end",   am_wc, 0);
    check("am_ctrl",     am_ctrl, c);
  endtask

  initial begin
    logic [DW-1:0] ra;
    bus.Start = 0; bus.StartAddress = '0; bus.WordCount = '0; bus.ControlWord = '0;
    bus.Abort = 0; bus.MemAck = 0; bus.Done = 0; bus.AmDataIn = '0;

    tick();
    tick();
    check("rst_op",   bus.Instruction, OP_RD_CTRL);
    check("rst_data", bus.AmDataOut, 0);
    check("rst_aci",  bus.ACI, 1);
    check("rst_wci",  bus.WCI, 1);
    check("rst_req",  bus.MemReq, 0);
    check("rst_busy", bus.Busy, 0);
    check("rst_xfer", bus.XferDone, 0);
    check("rst_err",  bus.Error, 0);
    Reset_n = 1'b1;
    tick();

    full_xfer(8'h10, 3, 3'b010, 2);
    full_xfer(8'($urandom), 5, 3'($urandom), 1);
    for (int i = 0; i < 6; i++) begin
      full_xfer(8'($urandom), int'($urandom_range(1, 6)), 3'($urandom), 0);
    end

    // Abort coinciding with the second acknowledge
    start_xfer(8'h40, 8'h04, 3'b101, 1'b0);
    run_words(4, 1, 1);
    check("abort_addr", am_addr, 8'h41);

    // Memory never answers: timeout path
    start_xfer(8'h20, 8'h02, 3'b011, 1'b0);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      check("to_wait_req", bus.MemReq, 1);
      check("to_wait_err", bus.Error, 0);
    end
    tick();
    check("to_op",  bus.Instruction, OP_REINIT);
    check("to_err", bus.Error, 1);
    check("to_req", bus.MemReq, 0);
    tick();
    check("to_idle",   bus.Busy, 0);
    check("to_sticky", bus.Error, 1);
    full_xfer(8'h30, 2, 3'b110, 0);

`ifdef READBACK_VERIFY_EN
    start_xfer(8'h50, 8'h02, 3'b100, 1'b1);
    check("vfy_op",  bus.Instruction, OP_REINIT);
    check("vfy_err", bus.Error, 1);
    check("vfy_req", bus.MemReq, 0);
    tick();
    check("vfy_idle", bus.Busy, 0);
`endif

    // Asynchronous reset while a count pulse is on the wire
    ra = 8'($urandom);
    start_xfer(ra, 8'h04, 3'b001, 1'b0);
    bus.MemAck = 1'b1;
    tick();
    bus.MemAck = 1'b0;
    check("pre_rst_aci", bus.ACI, 0);
    Reset_n = 1'b0;
    #1;
    check("arst_op",   bus.Instruction, OP_RD_CTRL);
    check("arst_aci",  bus.ACI, 1);
    check("arst_wci",  bus.WCI, 1);
    check("arst_req",  bus.MemReq, 0);
    check("arst_busy", bus.Busy, 0);
    check("arst_xfer", bus.XferDone, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    tick();
    check("post_rst_busy", bus.Busy, 0);
    full_xfer(8'hF0, 3, 3'b111, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
